// File: rtl/fifo_operand_reader.sv
// -----------------------------------------------------------------------------
// fifo_operand_reader
//
// Read-side sequencer for the 8-entry operand FIFO. Issues one single-word read
// request per operand to the FIFO control FSM and captures two consecutive
// words as ALU operands A and B. It then presents the pair to the ALU with a
// valid/ready handshake. Write-side requests are muxed onto en/rd_wr_sw
// outside this block.
//
// Parameters
//   DATA_W   width of one FIFO word and of each operand
//   TIMEOUT  cycles to wait for rd_en after a request pulse (3..7)
//
// Ports
//   clock          in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   start          in   fetch one operand pair (sampled only in IDLE)
//   fifo_empty     in   FIFO empty flag from the control FSM
//   rd_en          in   read strobe; rd_data valid while high
//   rd_data        in   FIFO read data
//   op_ready       in   ALU accepts the presented operands
//   en             out  FIFO request enable, one-cycle pulse per word
//   rd_wr_sw       out  request direction, always 0 (read)
//   op_a, op_b     out  captured operands
//   op_valid       out  operands valid
//   busy           out  sequencer not in IDLE
//   underflow_err  out  sticky read timeout; cleared by reset or next start
//   pair_count     out  pairs handed off, wraps 255 -> 0
// -----------------------------------------------------------------------------
module fifo_operand_reader #(
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic              fifo_empty,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              op_ready,
    output logic              en,
    output logic              rd_wr_sw,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_valid,
    output logic              busy,
    output logic              underflow_err,
    output logic [7:0]        pair_count
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_A,
        WAIT_A,
        REQ_B,
        WAIT_B,
        PRESENT
    } state_t;

    localparam logic [2:0] TMO_LOAD = 3'(TIMEOUT);

    state_t              state;
    state_t              state_next;
    logic [2:0]          tmo;
    logic [2:0]          tmo_next;
    logic                en_next;
    logic [DATA_W-1:0]   op_a_next;
    logic [DATA_W-1:0]   op_b_next;
    logic                err_next;
    logic [7:0]          pair_next;

    // Reads never share the request lines with this block's own direction.
    assign rd_wr_sw = 1'b0;

    // en is a register, so the emptiness check is made on the edge that
    // enters (or re-enters) a REQ cycle; the pulse then lines up with that
    // REQ cycle. A REQ cycle that already carries the pulse moves on to WAIT
    // and clears en, so en can never be high two cycles running.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_next = state;
        tmo_next   = tmo;
        en_next    = 1'b0;
        op_a_next  = op_a;
        op_b_next  = op_b;
        err_next   = underflow_err;
        pair_next  = pair_count;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = REQ_A;
                    err_next   = 1'b0;
                    en_next    = !fifo_empty;
                end
            end
            REQ_A: begin
                if (en) begin
                    state_next = WAIT_A;
                    tmo_next   = TMO_LOAD;
                end else begin
                    en_next = !fifo_empty;
                end
            end
            WAIT_A: begin
                if (rd_en) begin
                    op_a_next  = rd_data;
                    state_next = REQ_B;
                    en_next    = !fifo_empty;
                end else if (tmo == 3'd1) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo - 3'd1;
                end
            end
            REQ_B: begin
                if (en) begin
                    state_next = WAIT_B;
                    tmo_next   = TMO_LOAD;
                end else begin
                    en_next = !fifo_empty;
                end
            end
            WAIT_B: begin
                if (rd_en) begin
                    op_b_next  = rd_data;
                    state_next = PRESENT;
                end else if (tmo == 3'd1) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo - 3'd1;
                end
            end
            PRESENT: begin
                if (op_ready) begin
                    pair_next  = pair_count + 8'd1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // busy and op_valid are registered copies of the next-state decode, so
    // they change on the same edge as the state itself.
    always_ff @(posedge clock or posedge rst) begin
        // NOTE: every register here, operands included, has a reset value;
        // these are plain flops, not a memory array, so resetting them is cheap.
        if (rst) begin
            state         <= IDLE;
            tmo           <= '0;
            en            <= 1'b0;
            op_a          <= '0;
            op_b          <= '0;
            op_valid      <= 1'b0;
            busy          <= 1'b0;
            underflow_err <= 1'b0;
            pair_count    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state         <= state_next;
            tmo           <= tmo_next;
            en            <= en_next;
            op_a          <= op_a_next;
            op_b          <= op_b_next;
            op_valid      <= (state_next == PRESENT);
            busy          <= (state_next != IDLE);
            underflow_err <= err_next;
            pair_count    <= pair_next;
        end
    end

endmodule

// File: tb/tb_fifo_operand_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_operand_reader
//
// Directed bench for fifo_operand_reader. A small behavioural FIFO/control-FSM
// model answers each en pulse with rd_en two cycles later (and can be stalled
// to withhold rd_en). Cycle 0 is the cycle in which start is driven high.
// -----------------------------------------------------------------------------
module tb_fifo_operand_reader;

    localparam int DATA_W  = 4;
    localparam int TIMEOUT = 4;

    logic              clock = 1'b0;
    logic              rst;
    logic              start;
    logic              fifo_empty;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              op_ready;
    logic              en;
    logic              rd_wr_sw;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_valid;
    logic              busy;
    logic              underflow_err;
    logic [7:0]        pair_count;

    fifo_operand_reader #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock         (clock),
        .rst           (rst),
        .start         (start),
        .fifo_empty    (fifo_empty),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .op_ready      (op_ready),
        .en            (en),
        .rd_wr_sw      (rd_wr_sw),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_valid      (op_valid),
        .busy          (busy),
        .underflow_err (underflow_err),
        .pair_count    (pair_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // FIFO / control-FSM model
    logic [DATA_W-1:0] fifo_q[$];
    logic              stall;
    logic              pipe1_v = 1'b0;
    logic              pipe2_v = 1'b0;
    logic [DATA_W-1:0] pipe1_d = '0;
    logic [DATA_W-1:0] pipe2_d = '0;

    // Advance one clock; sample just after the edge and update the model:
    // the word is reserved at the en cycle and returned on rd_en two later.
    task automatic step();
        @(posedge clock);
        #1;
        rd_en   = pipe2_v && !stall;
        rd_data = pipe2_v ? pipe2_d : '0;
        pipe2_v = pipe1_v;
        pipe2_d = pipe1_d;
        pipe1_v = en;
        if (en) pipe1_d = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        fifo_q.push_back(d);
        fifo_empty = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!op_valid && n < budget) begin
            step();
            n++;
        end
        if (!op_valid) check(tag, 0, 1);
    endtask

    // en adjacency monitor
    logic en_prev = 1'b0;
    int   en_b2b  = 0;
    always @(negedge clock) begin
        if (!rst && en && en_prev) en_b2b++;
        en_prev = rst ? 1'b0 : en;
    end

    initial begin
        int en_mask, valid_mask, a7, b7, pc0;
        int en_first, en_second, en_cnt, valid_at, err_at, busy_at_err;
        int saw_valid, stable, en_seen, op_err, pc_254;

        rst = 1'b1; start = 1'b0; fifo_empty = 1'b1; rd_en = 1'b0;
        rd_data = '0; op_ready = 1'b0; stall = 1'b0;
        #2;
        check("rst_en",       int'(en), 0);
        check("rst_rd_wr_sw", int'(rd_wr_sw), 0);
        check("rst_op_a",     int'(op_a), 0);
        check("rst_op_b",     int'(op_b), 0);
        check("rst_valid",    int'(op_valid), 0);
        check("rst_busy",     int'(busy), 0);
        check("rst_err",      int'(underflow_err), 0);
        check("rst_pairs",    int'(pair_count), 0);
        #20;
        rst = 1'b0;
        step();

        // 1: best case, op_ready held high
        push(3); push(9); op_ready = 1'b1;
        en_mask = 0; valid_mask = 0; a7 = -1; b7 = -1;
        start_pulse();
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) step();
            if (en) en_mask |= (1 << c);
            if (op_valid) valid_mask |= (1 << c);
            if (c == 7) begin a7 = int'(op_a); b7 = int'(op_b); end
        end
        check("t1_en_cycles",    en_mask, 'h12);
        check("t1_valid_cycles", valid_mask, 'h80);
        check("t1_op_a",         a7, 3);
        check("t1_op_b",         b7, 9);
        check("t1_pairs",        int'(pair_count), 1);
        check("t1_busy_after",   int'(busy), 0);

        // 2: FIFO empty at start, words arrive at cycles 10 and 20
        en_first = -1; en_second = -1; en_cnt = 0; valid_at = -1;
        start_pulse();
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) step();
            if (c == 10) push(5);
            if (c == 20) push(6);
            if (en) begin
                en_cnt++;
                if (en_first < 0) en_first = c; else en_second = c;
            end
            if (op_valid && valid_at < 0) begin
                valid_at = c;
                a7 = int'(op_a);
                b7 = int'(op_b);
            end
        end
        check("t2_en_count",  en_cnt, 2);
        check("t2_en_first",  en_first, 11);
        check("t2_en_second", en_second, 21);
        check("t2_valid_at",  valid_at, 24);
        check("t2_op_a",      a7, 5);
        check("t2_op_b",      b7, 6);
        check("t2_err",       int'(underflow_err), 0);
        check("t2_pairs",     int'(pair_count), 2);

        // 3: rd_en withheld -> underflow after TIMEOUT+1 cycles
        stall = 1'b1; push(7); push(8);
        start_pulse();
        check("t3_en_pulse", int'(en), 1);
        err_at = -1; busy_at_err = -1; saw_valid = 0;
        for (int c = 2; c <= 10; c++) begin
            step();
            if (underflow_err && err_at < 0) begin
                err_at = c;
                busy_at_err = int'(busy);
            end
            if (op_valid) saw_valid = 1;
        end
        check("t3_err_cycle",  err_at, 1 + TIMEOUT + 1);
        check("t3_busy_err",   busy_at_err, 0);
        check("t3_no_valid",   saw_valid, 0);
        check("t3_op_a_kept",  int'(op_a), 5);
        stall = 1'b0;
        fifo_q.delete();
        fifo_empty = 1'b1;
        push(1); push(2);
        start_pulse();
        check("t3_err_clear", int'(underflow_err), 0);
        wait_valid("t3_valid_timeout", 20);
        check("t3_op_a", int'(op_a), 1);
        check("t3_op_b", int'(op_b), 2);
        step();
        check("t3_pairs", int'(pair_count), 3);

        // 4: op_ready low for 10 cycles in PRESENT, start pulses ignored
        op_ready = 1'b0; push(4'hA); push(4'hB);
        start_pulse();
        for (int c = 2; c <= 7; c++) step();
        check("t4_valid_c7", int'(op_valid), 1);
        a7 = int'(op_a); b7 = int'(op_b); pc0 = int'(pair_count);
        check("t4_op_a", a7, 10);
        check("t4_op_b", b7, 11);
        stable = 1; en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            start = (i % 3 == 1);
            step();
            start = 1'b0;
            if (!op_valid || int'(op_a) != a7 || int'(op_b) != b7 ||
                int'(pair_count) != pc0) stable = 0;
            if (en) en_seen = 1;
        end
        check("t4_stable",  stable, 1);
        check("t4_no_en",   en_seen, 0);
        check("t4_pairs_hold", int'(pair_count), 3);
        op_ready = 1'b1;
        step();
        check("t4_pairs_inc",  int'(pair_count), 4);
        check("t4_valid_drop", int'(op_valid), 0);
        check("t4_busy_drop",  int'(busy), 0);
        step();
        check("t4_no_queue", int'(busy) + int'(en), 0);

        // 5: reset in WAIT_B
        push(4); push(5); push(6); push(7);
        start_pulse();
        for (int c = 2; c <= 5; c++) step();
        check("t5_busy_wb",  int'(busy), 1);
        check("t5_op_a_wb",  int'(op_a), 4);
        rst = 1'b1;
        #1;
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_op_a", int'(op_a), 0);
        check("t5_rst_err",  int'(underflow_err) + int'(en) + int'(op_valid), 0);
        check("t5_rst_pairs", int'(pair_count), 0);
        step();
        rst = 1'b0;
        check("t5_late_rd_en", int'(rd_en), 1);
        step();
        check("t5_ignored_b",     int'(op_b), 0);
        check("t5_ignored_valid", int'(op_valid) + int'(busy), 0);
        start_pulse();
        wait_valid("t5_valid_timeout", 20);
        check("t5_op_a", int'(op_a), 6);
        check("t5_op_b", int'(op_b), 7);
        step();
        check("t5_pairs", int'(pair_count), 1);

        // 6: 256 back-to-back pairs from reset -> pair_count wraps to 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        op_err = 0; pc_254 = -1;
        for (int i = 0; i < 256; i++) begin
            push(DATA_W'(i));
            push(DATA_W'(i * 7 + 3));
            start_pulse();
            wait_valid("t6_valid_timeout", 20);
            if (int'(op_a) != (i & 15) || int'(op_b) != ((i * 7 + 3) & 15))
                op_err++;
            step();
            if (i == 254) pc_254 = int'(pair_count);
        end
        check("t6_operands", op_err, 0);
        check("t6_pairs_255", pc_254, 255);
        check("t6_pairs_wrap", int'(pair_count), 0);
        check("en_back_to_back", en_b2b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
